// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: one outstanding imem read at the current PC. Returned
// words are queued with their PC for decode. The PC register write enable is driven from here.
module if_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    flush_i,
  input  logic [ADDR_W-1:0]       pc_i,
  output logic                    pc_write_o,
  output logic                    imem_req_o,
  output logic [ADDR_W-1:0]       imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [DATA_W-1:0]       imem_data_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [DATA_W-1:0]       id_instr_o,
  output logic [ADDR_W-1:0]       id_pc_o,
  output logic [ADDR_W-1:0]       id_pc4_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  logic [DATA_W-1:0]  instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Issuing only below DEPTH reserves the slot the eventual push will use.
        if (start_i && !flush_i && (count_q < DEPTH_C)) begin
          addr_d  = pc_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          push    = !flush_i;
          state_d = IDLE;
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign id_valid_o = (count_q != '0);
  assign pop        = id_valid_o && id_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; empty entries never reach the outputs because they are gated by id_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data_i;
      pc_mem_q[wr_ptr_q]    <= addr_q;
    end
  end

  assign imem_req_o  = (state_q != IDLE);
  assign imem_addr_o = addr_q;
  assign count_o     = count_q;

  // Held low during reset so a stray flush or ack cannot move the PC register.
  assign pc_write_o = rst_i && (flush_i || ((state_q == REQ) && imem_ack_i));

  assign id_instr_o = id_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign id_pc_o    = id_valid_o ? pc_mem_q[rd_ptr_q]    : '0;
  assign id_pc4_o   = id_valid_o ? (pc_mem_q[rd_ptr_q] + ADDR_W'(4)) : '0;

  count_bound_a: assert property (@(posedge clk_i) disable iff (!rst_i) count_q <= DEPTH_C);

endmodule
